packet_register_responder: RTL and testbench

//  Register-access responder at the far end of the UART packet link. It consumes

---
 rtl/packet_register_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_packet_register_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_register_responder.sv
// Register-access responder for the UART packet link: parses read/write
// requests, executes them on a local 32-bit register file, and returns one reply
// packet per addressed request. The first reply beat appears on the cycle after
// the request's EoP beat. The Rx side is never stalled. Requests that arrive
// while a reply is still pending are dropped and counted.
//
// Ports:
//   ipClk        system clock
//   ipReset      asynchronous reset, active-high
//   ipRxStream   request beats from the packet receiver (no backpressure)
//   ipTxReady    transmitter ready; a beat moves on opTxStream.Valid && ipTxReady
//   opTxStream   reply beats to the packet transmitter
//   opRegisters  register file, register n at [32n+31:32n]
//   opWrStrobe   one-cycle pulse on the bit of the register being written
//   opDropCount  saturating count of dropped or abandoned requests

package uart_packet_pkg;
  typedef struct packed {
    logic [7:0] Destination;
    logic [7:0] Source;
    logic [7:0] Length;
    logic [7:0] Data;
    logic       SoP;
    logic       EoP;
    logic       Valid;
  } UART_PACKET;
endpackage

module packet_register_responder
  import uart_packet_pkg::*;
#(
  parameter logic [7:0]  ADDRESS     = 8'h01,
  parameter int          REG_COUNT   = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                      ipClk,
  input  logic                      ipReset,
  input  UART_PACKET                ipRxStream,
  input  logic                      ipTxReady,
  output UART_PACKET                opTxStream,
  output logic [32*REG_COUNT-1:0]   opRegisters,
  output logic [REG_COUNT-1:0]      opWrStrobe,
  output logic [7:0]                opDropCount
);

  // The start beat carries the command byte, so Idle captures it directly and
  // parsing continues at the address beat.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_WAIT_EOP,
    ST_EXEC,
    ST_TX
  } state_t;

  localparam logic [8:0] REG_LIMIT = 9'(REG_COUNT);

  state_t                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [7:0]            src_q, src_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;      // beats received in the current request
  logic                  tx_vld_q, tx_vld_d;
  logic [7:0]            tx_dst_q, tx_dst_d;
  logic [7:0]            tx_src_q, tx_src_d;
  logic [7:0]            rep_len_q, rep_len_d;
  logic [2:0]            idx_q, idx_d;      // reply beat currently presented
  logic [7:0][7:0]       rep_q, rep_d;      // reply payload, byte k on beat k
  logic [REG_COUNT-1:0]  strobe_q, strobe_d;
  logic [7:0]            drop_q, drop_d;
  logic [31:0]           regs_q [REG_COUNT];

  logic                  rx_start, rx_mine, take_start, take_body, load_reply, last_beat;
  logic [7:0]            status;
  logic [31:0]           rd_word;

  assign rx_start  = ipRxStream.Valid && ipRxStream.SoP;
  assign rx_mine   = rx_start && (ipRxStream.Destination == ADDRESS);
  assign last_beat = ({5'd0, idx_q} == (rep_len_q - 8'd1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    src_d      = src_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tx_vld_d   = tx_vld_q;
    tx_dst_d   = tx_dst_q;
    tx_src_d   = tx_src_q;
    rep_len_d  = rep_len_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    strobe_d   = '0;
    drop_d     = drop_q;
    take_start = 1'b0;
    take_body  = 1'b0;
    status     = 8'h00;
    rd_word    = 32'h0;

    case (state_q)
      ST_IDLE: take_start = rx_mine;
      ST_RX_ADDR, ST_RX_DATA, ST_WAIT_EOP: begin
        if (rx_start) begin
          // A new packet before EoP abandons the request in progress.
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          take_start = rx_mine;
          if (!rx_mine) state_d = ST_IDLE;
        end else begin
          take_body = ipRxStream.Valid;
        end
      end
      ST_EXEC, ST_TX: begin
        if (rx_mine && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        // Exec already presents beat 0, so both states run the Tx handshake.
        if (tx_vld_q && ipTxReady) begin
          if (last_beat) begin
            tx_vld_d = 1'b0;
            idx_d    = 3'd0;
            state_d  = ST_IDLE;
          end else begin
            idx_d    = idx_q + 3'd1;
            state_d  = ST_TX;
          end
        end else begin
          state_d = ST_TX;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_start) begin
      src_d   = ipRxStream.Source;
      len_d   = ipRxStream.Length;
      cmd_d   = ipRxStream.Data;
      addr_d  = 8'h00;
      data_d  = 32'h0;
      cnt_d   = 8'd1;
      state_d = ST_RX_ADDR;
    end else if (take_body) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      case (state_q)
        ST_RX_ADDR: begin
          addr_d  = ipRxStream.Data;
          state_d = (cmd_q == 8'h01) ? ST_RX_DATA : ST_WAIT_EOP;
        end
        ST_RX_DATA: begin
          case (cnt_q)
            8'd2: data_d[7:0]   = ipRxStream.Data;
            8'd3: data_d[15:8]  = ipRxStream.Data;
            8'd4: data_d[23:16] = ipRxStream.Data;
            8'd5: begin
              data_d[31:24] = ipRxStream.Data;
              state_d       = ST_WAIT_EOP;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    // Validation and reply building happen as the EoP beat is taken so the
    // strobe and the first reply beat are both registered for the Exec cycle.
    load_reply = (take_start || take_body) && ipRxStream.EoP;

    if ((cmd_d != 8'h00 && cmd_d != 8'h01) ||
        (cmd_d == 8'h00 && len_d != 8'd2) ||
        (cmd_d == 8'h01 && len_d != 8'd6) ||
        (cnt_d != len_d))
      status = 8'h02;
    else if ({1'b0, addr_d} >= REG_LIMIT)
      status = 8'h01;

    if (status == 8'h00) begin
      for (int n = 0; n < REG_COUNT; n++)
        if (addr_d == 8'(n)) rd_word = regs_q[n];
    end

    if (load_reply) begin
      state_d  = ST_EXEC;
      tx_vld_d = 1'b1;
      tx_dst_d = src_d;
      tx_src_d = ADDRESS;
      idx_d    = 3'd0;
      rep_d    = '0;
      rep_d[0] = status;
      rep_d[1] = addr_d;
      if (cmd_d == 8'h00 && status != 8'h02) begin
        rep_len_d = 8'd6;
        rep_d[2]  = rd_word[7:0];
        rep_d[3]  = rd_word[15:8];
        rep_d[4]  = rd_word[23:16];
        rep_d[5]  = rd_word[31:24];
      end else begin
        rep_len_d = 8'd2;
      end
      for (int n = 0; n < REG_COUNT; n++)
        strobe_d[n] = (status == 8'h00) && (cmd_d == 8'h01) && (addr_d == 8'(n));
    end
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 32'h0;
      src_q     <= 8'h00;
      len_q     <= 8'h00;
      cnt_q     <= 8'h00;
      tx_vld_q  <= 1'b0;
      tx_dst_q  <= 8'h00;
      tx_src_q  <= 8'h00;
      rep_len_q <= 8'h00;
      idx_q     <= 3'd0;
      rep_q     <= '0;
      strobe_q  <= '0;
      drop_q    <= 8'h00;
      for (int n = 0; n < REG_COUNT; n++) regs_q[n] <= RESET_VALUE;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      src_q     <= src_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      tx_vld_q  <= tx_vld_d;
      tx_dst_q  <= tx_dst_d;
      tx_src_q  <= tx_src_d;
      rep_len_q <= rep_len_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      strobe_q  <= strobe_d;
      drop_q    <= drop_d;
      // The write lands at the end of the strobe cycle; data_q is frozen in Exec.
      for (int n = 0; n < REG_COUNT; n++)
        if (strobe_q[n]) regs_q[n] <= data_q;
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs_out
    assign opRegisters[32*g +: 32] = regs_q[g];
  end

  assign opTxStream.Destination = tx_dst_q;
  assign opTxStream.Source      = tx_src_q;
  assign opTxStream.Length      = rep_len_q;
  assign opTxStream.Data        = rep_q[idx_q];
  assign opTxStream.SoP         = tx_vld_q && (idx_q == 3'd0);
  assign opTxStream.EoP         = tx_vld_q && last_beat;
  assign opTxStream.Valid       = tx_vld_q;
  assign opWrStrobe             = strobe_q;
  assign opDropCount            = drop_q;

endmodule

// File: tb/tb_packet_register_responder.sv
module tb_packet_register_responder;
  import uart_packet_pkg::*;

  localparam int          RC = 16;
  localparam logic [31:0] RV = 32'hC0DE_0001;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  UART_PACKET        rx_stream;
  logic              tx_ready;
  UART_PACKET        tx_stream;
  logic [32*RC-1:0]  regs_bus;
  logic [RC-1:0]     wr_strobe;
  logic [7:0]        drop_cnt;

  packet_register_responder #(.ADDRESS(8'h01), .REG_COUNT(RC), .RESET_VALUE(RV)) dut (
    .ipClk(clk), .ipReset(rst), .ipRxStream(rx_stream), .ipTxReady(tx_ready),
    .opTxStream(tx_stream), .opRegisters(regs_bus), .opWrStrobe(wr_strobe),
    .opDropCount(drop_cnt)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] m_regs [RC];
  int          m_drops = 0;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int n = 0; n < RC; n++) m_regs[n] = RV;
    m_drops = 0;
  endfunction

  function automatic logic [32*RC-1:0] m_vec();
    logic [32*RC-1:0] v;
    for (int n = 0; n < RC; n++) v[32*n +: 32] = m_regs[n];
    return v;
  endfunction

  // Applies an addressed request to the model; returns reply bytes and strobe mask.
  function automatic void model_req(input logic [7:0] len, input byte_q_t pl,
                                    output byte_q_t rep, output logic [RC-1:0] stb);
    int          n;
    logic [7:0]  cmd, addr, st;
    logic [31:0] word;
    n    = pl.size();
    cmd  = pl[0];
    addr = (n >= 2) ? pl[1] : 8'h00;
    stb  = '0;
    rep  = {};
    if (!(cmd == 8'h00 || cmd == 8'h01) || (cmd == 8'h00 && len != 8'd2) ||
        (cmd == 8'h01 && len != 8'd6) || n != int'(len)) st = 8'h02;
    else if (int'(addr) >= RC) st = 8'h01;
    else st = 8'h00;
    if (st == 8'h00 && cmd == 8'h01) begin
      m_regs[addr[3:0]] = {pl[5], pl[4], pl[3], pl[2]};
      stb[addr[3:0]] = 1'b1;
    end
    rep.push_back(st);
    rep.push_back(addr);
    if (cmd == 8'h00 && st != 8'h02) begin
      word = (st == 8'h00) ? m_regs[addr[3:0]] : 32'h0;
      for (int k = 0; k < 4; k++) rep.push_back(word[8*k +: 8]);
    end
  endfunction

  function automatic logic [63:0] q2v(input byte_q_t q);
    logic [63:0] v;
    v = '0;
    v[63:56] = 8'(q.size());
    for (int k = 0; k < q.size() && k < 7; k++) v[8*(6-k) +: 8] = q[k];
    return v;
  endfunction

  // ---------------- stimulus / observation (no checks) ----------------
  task automatic send_req(input logic [7:0] dst, src, len, input byte_q_t pl);
    for (int i = 0; i < pl.size(); i++) begin
      rx_stream.Valid       = 1'b1;
      rx_stream.SoP         = (i == 0);
      rx_stream.EoP         = (i == pl.size() - 1);
      rx_stream.Destination = (i == 0) ? dst : 8'($urandom);
      rx_stream.Source      = (i == 0) ? src : 8'($urandom);
      rx_stream.Length      = (i == 0) ? len : 8'($urandom);
      rx_stream.Data        = pl[i];
      @(negedge clk);
    end
    rx_stream = '0;
  endtask

  task automatic collect(input int rdy_pct, input int first_idx, output byte_q_t bytes,
                         output logic [7:0] rdst, rsrc, rlen, output logic fmt_ok, done);
    int         idx;
    logic       stalled;
    UART_PACKET prev;
    idx = first_idx; bytes = {}; rdst = 0; rsrc = 0; rlen = 0;
    fmt_ok = 1'b1; done = 1'b0; stalled = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (stalled && tx_stream !== prev) fmt_ok = 1'b0;
      tx_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      stalled  = tx_stream.Valid && !tx_ready;
      prev     = tx_stream;
      if (tx_stream.Valid && tx_ready) begin
        if (idx == first_idx) begin
          rdst = tx_stream.Destination; rsrc = tx_stream.Source; rlen = tx_stream.Length;
        end else if (tx_stream.Destination !== rdst || tx_stream.Source !== rsrc ||
                     tx_stream.Length !== rlen) fmt_ok = 1'b0;
        if (tx_stream.SoP !== (idx == 0)) fmt_ok = 1'b0;
        bytes.push_back(tx_stream.Data);
        idx++;
        if (tx_stream.EoP) done = 1'b1;
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    if (done && tx_stream.Valid) fmt_ok = 1'b0;
  endtask

  task automatic transact(input logic [7:0] dst, src, len, input byte_q_t pl, input int rdy_pct,
                          output logic [RC-1:0] stb, output byte_q_t bytes,
                          output logic [7:0] rdst, rsrc, rlen, output logic fmt_ok, done);
    send_req(dst, src, len, pl);
    stb = wr_strobe;
    collect(rdy_pct, 0, bytes, rdst, rsrc, rlen, fmt_ok, done);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rx_stream = '0; tx_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++; if (tx_stream !== '0) begin errors++; $display("FAIL reset_tx: got %h expected 0", tx_stream); end
    vectors++; if (wr_strobe !== '0) begin errors++; $display("FAIL reset_strobe: got %h expected 0", wr_strobe); end
    vectors++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drops: got %h expected 0", drop_cnt); end
    vectors++; if (regs_bus !== m_vec()) begin errors++; $display("FAIL reset_regs: got %h expected %h", regs_bus, m_vec()); end
  endtask

  task automatic test_write_read();
    byte_q_t pl, exp, got; logic [RC-1:0] stb, es; logic [7:0] d, s, l; logic ok, done;
    pl = {8'h01, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12};
    model_req(8'd6, pl, exp, es);
    send_req(8'h01, 8'h10, 8'd6, pl);
    vectors++; if (wr_strobe !== 16'h0008) begin errors++; $display("FAIL wr_strobe_n1: got %h expected 0008", wr_strobe); end
    vectors++; if (!(tx_stream.Valid && tx_stream.SoP)) begin errors++; $display("FAIL first_beat_n1: got v%b s%b expected v1 s1", tx_stream.Valid, tx_stream.SoP); end
    vectors++; if (regs_bus[3*32 +: 32] !== RV) begin errors++; $display("FAIL reg3_n1: got %h expected %h", regs_bus[3*32 +: 32], RV); end
    @(negedge clk);
    vectors++; if (wr_strobe !== '0) begin errors++; $display("FAIL wr_strobe_n2: got %h expected 0", wr_strobe); end
    vectors++; if (regs_bus[3*32 +: 32] !== 32'h12345678) begin errors++; $display("FAIL reg3_n2: got %h expected 12345678", regs_bus[3*32 +: 32]); end
    collect(100, 0, got, d, s, l, ok, done);
    vectors++; if (q2v(got) !== q2v(exp)) begin errors++; $display("FAIL write_reply: got %h expected %h", q2v(got), q2v(exp)); end
    vectors++; if ({d, s, l, ok, done} !== {8'h10, 8'h01, 8'd2, 2'b11}) begin errors++; $display("FAIL write_hdr: got %h %h %h ok%b done%b expected 10 01 02 ok1 done1", d, s, l, ok, done); end
    pl = {8'h00, 8'h03};
    model_req(8'd2, pl, exp, es);
    transact(8'h01, 8'h10, 8'd2, pl, 60, stb, got, d, s, l, ok, done);
    vectors++; if (stb !== '0) begin errors++; $display("FAIL read_strobe: got %h expected 0", stb); end
    vectors++; if (q2v(got) !== q2v(exp)) begin errors++; $display("FAIL read_reply: got %h expected %h", q2v(got), q2v(exp)); end
    vectors++; if ({d, s, l, ok, done} !== {8'h10, 8'h01, 8'd6, 2'b11}) begin errors++; $display("FAIL read_hdr: got %h %h %h ok%b done%b expected 10 01 06 ok1 done1", d, s, l, ok, done); end
  endtask

  task automatic test_errors();
    byte_q_t pl, exp, got; logic [RC-1:0] stb, es; logic [7:0] d, s, l, len; logic ok, done;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin pl = {8'h00, 8'h20}; len = 8'd2; end
        1: begin pl = {8'h01, 8'h05, 8'hAA}; len = 8'd3; end
        2: begin pl = {8'h01, 8'h02, 8'h11, 8'h22, 8'h33}; len = 8'd6; end
        3: begin pl = {8'h07, 8'h01}; len = 8'd2; end
        4: begin pl = {8'h00}; len = 8'd1; end
        default: begin pl = {8'h00, 8'h04}; len = 8'd6; end
      endcase
      model_req(len, pl, exp, es);
      transact(8'h01, 8'h22, len, pl, 70, stb, got, d, s, l, ok, done);
      vectors++; if (stb !== es) begin errors++; $display("FAIL err%0d_strobe: got %h expected %h", i, stb, es); end
      vectors++; if (q2v(got) !== q2v(exp)) begin errors++; $display("FAIL err%0d_reply: got %h expected %h", i, q2v(got), q2v(exp)); end
      vectors++; if ({d, s, l, ok, done} !== {8'h22, 8'h01, 8'(exp.size()), 2'b11}) begin errors++; $display("FAIL err%0d_hdr: got %h %h %h ok%b done%b", i, d, s, l, ok, done); end
    end
    vectors++; if (regs_bus !== m_vec()) begin errors++; $display("FAIL err_regs: got %h expected %h", regs_bus, m_vec()); end
  endtask

  task automatic test_foreign();
    byte_q_t pl, got; logic [RC-1:0] stb; logic [7:0] d, s, l; logic ok, done;
    pl = {8'h01, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    transact(8'h02, 8'h10, 8'd6, pl, 100, stb, got, d, s, l, ok, done);
    vectors++; if (done !== 1'b0 || got.size() != 0) begin errors++; $display("FAIL foreign_reply: got %0d beats expected 0", got.size()); end
    vectors++; if (stb !== '0) begin errors++; $display("FAIL foreign_strobe: got %h expected 0", stb); end
    vectors++; if (regs_bus !== m_vec()) begin errors++; $display("FAIL foreign_regs: got %h expected %h", regs_bus, m_vec()); end
    vectors++; if (drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL foreign_drops: got %0d expected %0d", drop_cnt, m_drops); end
  endtask

  task automatic test_backpressure();
    byte_q_t pl, wpl, exp, got, tail; logic [RC-1:0] es; logic [7:0] d, s, l; logic ok, done;
    UART_PACKET snap; logic stable, stb_seen, extra;
    pl  = {8'h00, 8'h03};
    wpl = {8'h01, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
    model_req(8'd2, pl, exp, es);
    send_req(8'h01, 8'h30, 8'd2, pl);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    tx_ready = 1'b0;
    snap = tx_stream; stable = 1'b1; stb_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i >= 10 && i < 16) begin
        rx_stream.Valid = 1'b1; rx_stream.SoP = (i == 10); rx_stream.EoP = (i == 15);
        rx_stream.Destination = 8'h01; rx_stream.Source = 8'h31; rx_stream.Length = 8'd6;
        rx_stream.Data = wpl[i-10];
      end else rx_stream = '0;
      @(negedge clk);
      if (tx_stream !== snap) stable = 1'b0;
      if (wr_strobe !== '0) stb_seen = 1'b1;
    end
    m_drops++;
    vectors++; if (stable !== 1'b1 || snap.Data !== exp[2]) begin errors++; $display("FAIL bp_stable: got stable=%b data %h expected stable=1 data %h", stable, snap.Data, exp[2]); end
    vectors++; if (drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL bp_drops: got %0d expected %0d", drop_cnt, m_drops); end
    vectors++; if (stb_seen !== 1'b0 || regs_bus !== m_vec()) begin errors++; $display("FAIL bp_no_write: got strobe_seen=%b expected 0", stb_seen); end
    collect(50, 2, got, d, s, l, ok, done);
    tail = exp[2:5];
    vectors++; if (q2v(got) !== q2v(tail) || !ok || !done) begin errors++; $display("FAIL bp_tail: got %h ok%b expected %h ok1", q2v(got), ok, q2v(tail)); end
    extra = 1'b0;
    repeat (20) begin @(negedge clk); if (tx_stream.Valid) extra = 1'b1; end
    vectors++; if (extra !== 1'b0) begin errors++; $display("FAIL bp_single_reply: got extra reply, expected none"); end
  endtask

  task automatic test_abandon();
    byte_q_t pl, exp, got; logic [RC-1:0] stb, es; logic [7:0] d, s, l; logic ok, done;
    rx_stream = '0; rx_stream.Valid = 1'b1; rx_stream.SoP = 1'b1;
    rx_stream.Destination = 8'h01; rx_stream.Source = 8'h40; rx_stream.Length = 8'd6; rx_stream.Data = 8'h01;
    @(negedge clk);
    rx_stream.SoP = 1'b0; rx_stream.Data = 8'h07;
    @(negedge clk);
    m_drops++;
    pl = {8'h01, 8'h07, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
    model_req(8'd6, pl, exp, es);
    transact(8'h01, 8'h41, 8'd6, pl, 80, stb, got, d, s, l, ok, done);
    vectors++; if (drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL abandon_drops: got %0d expected %0d", drop_cnt, m_drops); end
    vectors++; if (stb !== es) begin errors++; $display("FAIL abandon_strobe: got %h expected %h", stb, es); end
    vectors++; if (q2v(got) !== q2v(exp) || d !== 8'h41) begin errors++; $display("FAIL abandon_reply: got %h dst %h expected %h dst 41", q2v(got), d, q2v(exp)); end
    vectors++; if (regs_bus !== m_vec()) begin errors++; $display("FAIL abandon_regs: got %h expected %h", regs_bus, m_vec()); end
  endtask

  task automatic test_random();
    byte_q_t pl, exp, got; logic [RC-1:0] stb, es; logic [7:0] d, s, l, len, dst, src;
    logic ok, done, foreign; int kind, n;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      kind = $urandom_range(0, 9);
      foreign = ($urandom_range(0, 9) == 0);
      dst = foreign ? 8'($urandom_range(2, 255)) : 8'h01;
      src = 8'($urandom);
      pl = {};
      if (kind < 5) begin
        pl = {8'h01, 8'($urandom_range(0, 15))};
        for (int k = 0; k < 4; k++) pl.push_back(8'($urandom));
        len = 8'd6;
      end else if (kind < 9) begin
        pl = {8'h00, 8'($urandom_range(0, 19))};
        len = 8'd2;
      end else begin
        n = $urandom_range(1, 7);
        pl.push_back(8'($urandom_range(0, 2)));
        for (int k = 1; k < n; k++) pl.push_back(8'($urandom_range(0, 19)));
        len = 8'($urandom_range(1, 8));
      end
      exp = {}; es = '0;
      if (!foreign) model_req(len, pl, exp, es);
      transact(dst, src, len, pl, $urandom_range(30, 100), stb, got, d, s, l, ok, done);
      vectors++; if (stb !== es) begin errors++; $display("FAIL rnd%0d_strobe: got %h expected %h", it, stb, es); end
      vectors++; if (done !== !foreign || q2v(got) !== q2v(exp)) begin errors++; $display("FAIL rnd%0d_reply: got %h done%b expected %h", it, q2v(got), done, q2v(exp)); end
      if (!foreign) begin
        vectors++; if ({d, s, l, ok} !== {src, 8'h01, 8'(exp.size()), 1'b1}) begin errors++; $display("FAIL rnd%0d_hdr: got %h %h %h ok%b expected %h 01 %h ok1", it, d, s, l, ok, src, 8'(exp.size())); end
      end
      vectors++; if (regs_bus !== m_vec() || drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL rnd%0d_state: got drops %0d expected %0d", it, drop_cnt, m_drops); end
    end
  endtask

  task automatic test_reset_mid_tx();
    byte_q_t pl, exp, got; logic [RC-1:0] stb, es; logic [7:0] d, s, l; logic ok, done, extra;
    pl = {8'h00, 8'h07};
    model_req(8'd2, pl, exp, es);
    send_req(8'h01, 8'h50, 8'd2, pl);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    tx_ready = 1'b0;
    vectors++; if (!tx_stream.Valid || tx_stream.Data !== exp[2]) begin errors++; $display("FAIL rst_beat2: got v%b %h expected v1 %h", tx_stream.Valid, tx_stream.Data, exp[2]); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++; if (tx_stream.Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", tx_stream.Valid); end
    vectors++; if (regs_bus !== m_vec() || drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_regs: got %h expected %h", regs_bus, m_vec()); end
    @(negedge clk);
    rst = 1'b0;
    extra = 1'b0;
    repeat (10) begin @(negedge clk); if (tx_stream.Valid) extra = 1'b1; end
    vectors++; if (extra !== 1'b0) begin errors++; $display("FAIL rst_no_resume: got reply after reset, expected none"); end
    model_req(8'd2, pl, exp, es);
    transact(8'h01, 8'h51, 8'd2, pl, 60, stb, got, d, s, l, ok, done);
    vectors++; if (q2v(got) !== q2v(exp) || !ok || d !== 8'h51) begin errors++; $display("FAIL rst_next_req: got %h expected %h", q2v(got), q2v(exp)); end
  endtask

  task automatic test_drop_saturation();
    byte_q_t pl, exp, got; logic [RC-1:0] es; logic [7:0] d, s, l; logic ok, done;
    pl = {8'h00, 8'h01};
    model_req(8'd2, pl, exp, es);
    send_req(8'h01, 8'h60, 8'd2, pl);
    rx_stream = '0; rx_stream.Valid = 1'b1; rx_stream.SoP = 1'b1; rx_stream.EoP = 1'b1;
    rx_stream.Destination = 8'h01; rx_stream.Length = 8'd1;
    repeat (300) @(negedge clk);
    rx_stream = '0;
    m_drops = (m_drops + 300 > 255) ? 255 : m_drops + 300;
    vectors++; if (drop_cnt !== 8'(m_drops)) begin errors++; $display("FAIL drop_saturate: got %h expected %h", drop_cnt, 8'(m_drops)); end
    collect(100, 0, got, d, s, l, ok, done);
    vectors++; if (q2v(got) !== q2v(exp) || !ok || !done) begin errors++; $display("FAIL drop_sat_reply: got %h expected %h", q2v(got), q2v(exp)); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_foreign();
    test_backpressure();
    test_abandon();
    test_random();
    test_reset_mid_tx();
    test_drop_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
